// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame |X[k]|^2 peak finder on the serial FFT bin stream.
// Define FFT_PEAK_SUM_EN to add the frame_energy output (sum of all bin powers).
module fft_peak_detect #(
    parameter int DW   = 24,
    parameter int NPTS = 8,
    parameter int IDXW = 3,
    parameter int PW   = 2*DW+1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_first,
    input  logic [DW-1:0]   in_real,
    input  logic [DW-1:0]   in_imag,
    output logic            peak_valid,
    input  logic            peak_ready,
    output logic [IDXW-1:0] peak_idx,
    output logic [PW-1:0]   peak_pow,
    output logic            overrun,
    output logic [7:0]      resync_cnt
`ifdef FFT_PEAK_SUM_EN
    ,
    output logic [PW+IDXW-1:0] frame_energy
`endif
);
    localparam logic [IDXW-1:0] LAST = IDXW'(NPTS-1);
    localparam int EW = PW+IDXW;

    typedef enum logic {SYNC, ACCUM} state_t;

    state_t r_state, w_state_nxt;
    logic [IDXW-1:0] r_cnt, w_cnt_nxt, w_tag;
    logic w_accept, w_abort;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state <= SYNC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end

    // After the last bin the counter sits at 0 in ACCUM: only in_first may follow.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tag       = r_cnt;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        if (in_valid) begin
            if (in_first) begin
                w_state_nxt = ACCUM;
                w_cnt_nxt   = IDXW'(1);
                w_tag       = '0;
                w_accept    = 1'b1;
                w_abort     = (r_state == ACCUM) && (r_cnt != '0);
            end else if (r_state == ACCUM && r_cnt != '0) begin
                w_cnt_nxt = r_cnt + 1'b1;
                w_accept  = 1'b1;
            end else begin
                w_state_nxt = SYNC;
            end
        end
    end

    logic signed [2*DW-1:0] w_re_x, w_im_x;
    assign w_re_x = (2*DW)'($signed(in_real));
    assign w_im_x = (2*DW)'($signed(in_imag));

    logic [2*DW-1:0] r_re2, r_im2;
    logic [IDXW-1:0] r_tag1, r_tag2, r_idx;
    logic [PW-1:0]   r_pow2, r_max;
    logic [EW-1:0]   r_energy;
    logic            r_v1, r_v2, r_last;
    logic            w_keep1, w_keep2;

    // An abort kills the partial frame; a previous frame's last bin may still be in flight.
    assign w_keep1 = r_v1 && !(w_abort && r_tag1 != LAST);
    assign w_keep2 = r_v2 && !(w_abort && r_tag2 != LAST);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_last   <= 1'b0;
            r_re2    <= '0;
            r_im2    <= '0;
            r_tag1   <= '0;
            r_tag2   <= '0;
            r_pow2   <= '0;
            r_max    <= '0;
            r_idx    <= '0;
            r_energy <= '0;
        end else begin
            r_v1   <= w_accept;
            r_v2   <= w_keep1;
            r_last <= w_keep2 && r_tag2 == LAST;
            if (w_accept) begin
                r_re2  <= w_re_x * w_re_x;
                r_im2  <= w_im_x * w_im_x;
                r_tag1 <= w_tag;
            end
            if (w_keep1) begin
                r_pow2 <= PW'(r_re2) + PW'(r_im2);
                r_tag2 <= r_tag1;
            end
            if (w_keep2 && (r_tag2 == '0 || r_pow2 > r_max)) begin
                r_max <= r_pow2;
                r_idx <= r_tag2;
            end
            if (w_keep2)
                r_energy <= (r_tag2 == '0 ? '0 : r_energy) + EW'(r_pow2);
        end

    logic            r_pv, r_ovr;
    logic [IDXW-1:0] r_out_idx;
    logic [PW-1:0]   r_out_pow;
    logic [7:0]      r_resync;
`ifdef FFT_PEAK_SUM_EN
    logic [EW-1:0]   r_out_energy;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_pv      <= 1'b0;
            r_ovr     <= 1'b0;
            r_out_idx <= '0;
            r_out_pow <= '0;
            r_resync  <= '0;
`ifdef FFT_PEAK_SUM_EN
            r_out_energy <= '0;
`endif
        end else begin
            r_pv  <= r_last | (r_pv & ~peak_ready);
            r_ovr <= r_ovr | (r_last & r_pv & ~peak_ready);
            if (r_last) begin
                r_out_idx <= r_idx;
                r_out_pow <= r_max;
`ifdef FFT_PEAK_SUM_EN
                r_out_energy <= r_energy;
`endif
            end
            if (w_abort && r_resync != 8'hFF)
                r_resync <= r_resync + 8'd1;
        end

    assign peak_valid = r_pv;
    assign peak_idx   = r_out_idx;
    assign peak_pow   = r_out_pow;
    assign overrun    = r_ovr;
    assign resync_cnt = r_resync;
`ifdef FFT_PEAK_SUM_EN
    assign frame_energy = r_out_energy;
`endif
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: randomized + directed bench against a frame-level reference model.
module tb_fft_peak_detect;
    localparam int DW = 24, NPTS = 8, IDXW = 3, PW = 2*DW+1;

    logic            clk = 1'b0, reset = 1'b0;
    logic            in_valid = 1'b0, in_first = 1'b0, peak_ready = 1'b0;
    logic [DW-1:0]   in_real = '0, in_imag = '0;
    logic            peak_valid, overrun;
    logic [IDXW-1:0] peak_idx;
    logic [PW-1:0]   peak_pow;
    logic [7:0]      resync_cnt;
`ifdef FFT_PEAK_SUM_EN
    logic [PW+IDXW-1:0] frame_energy;
`endif

    always #5 clk = ~clk;

    fft_peak_detect #(.DW(DW), .NPTS(NPTS), .IDXW(IDXW), .PW(PW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_first(in_first),
        .in_real(in_real), .in_imag(in_imag), .peak_valid(peak_valid),
        .peak_ready(peak_ready), .peak_idx(peak_idx), .peak_pow(peak_pow),
        .overrun(overrun), .resync_cnt(resync_cnt)
`ifdef FFT_PEAK_SUM_EN
        , .frame_energy(frame_energy)
`endif
    );

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: collect frames, compute results, schedule them 3 edges after the last bin.
    typedef struct {int due; int idx; longint pw; longint en;} res_t;
    res_t   pend[$];
    int     ecnt = 0;
    bit     m_pv = 0, m_ovr = 0, m_in = 0;
    int     m_idx = 0, m_res = 0, m_n = 0;
    longint m_pow = 0, m_en = 0;
    longint bp[NPTS];

    always @(posedge clk) begin : model
        longint re, im, s;
        int b;
        bit ld;
        ecnt++;
        if (reset) begin
            pend.delete();
            m_pv = 0; m_ovr = 0; m_in = 0;
            m_idx = 0; m_res = 0; m_n = 0;
            m_pow = 0; m_en = 0;
        end else begin
            ld = 0;
            if (pend.size() > 0)
                ld = (pend[0].due == ecnt);
            if (ld) begin
                if (m_pv && !peak_ready) m_ovr = 1;
                m_pv = 1;
                m_idx = pend[0].idx;
                m_pow = pend[0].pw;
                m_en = pend[0].en;
                void'(pend.pop_front());
            end else if (m_pv && peak_ready) begin
                m_pv = 0;
            end
            if (in_valid) begin
                re = longint'($signed(in_real));
                im = longint'($signed(in_imag));
                if (in_first) begin
                    if (m_in && m_n > 0 && m_res < 255) m_res++;
                    m_in = 1;
                    bp[0] = re*re + im*im;
                    m_n = 1;
                end else if (m_in && m_n > 0) begin
                    bp[m_n] = re*re + im*im;
                    m_n++;
                    if (m_n == NPTS) begin
                        b = 0;
                        s = 0;
                        for (int i = 0; i < NPTS; i++) begin
                            s += bp[i];
                            if (bp[i] > bp[b]) b = i;
                        end
                        pend.push_back('{ecnt + 3, b, bp[b], s});
                        m_n = 0;
                    end
                end else begin
                    m_in = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("valid", peak_valid, m_pv);
            check("overrun", overrun, m_ovr);
            check("resync", resync_cnt, m_res);
            if (m_pv) begin
                check("idx", peak_idx, m_idx);
                check("pow", peak_pow, m_pow);
`ifdef FFT_PEAK_SUM_EN
                check("energy", frame_energy, m_en);
`endif
            end
        end
    end

    int rmode = 0;
    int fre[NPTS], fim[NPTS];

    task automatic cyc(input bit v, input bit f, input int re, input int im);
        in_valid = v;
        in_first = f;
        in_real = DW'(re);
        in_imag = DW'(im);
        peak_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : rmode[0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    task automatic set_all(input int re, input int im);
        for (int i = 0; i < NPTS; i++) begin
            fre[i] = re;
            fim[i] = im;
        end
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < NPTS; i++) begin
            cyc(1, i == 0, fre[i], fim[i]);
            if (gap > 0 && i != NPTS-1) idle($urandom_range(0, gap));
        end
    endtask

    task automatic do_reset;
        in_valid = 0;
        in_first = 0;
        reset = 1;
        #1;
        check("rst_valid", peak_valid, 0);
        check("rst_idx", peak_idx, 0);
        check("rst_pow", peak_pow, 0);
        check("rst_ovr", overrun, 0);
        check("rst_resync", resync_cnt, 0);
`ifdef FFT_PEAK_SUM_EN
        check("rst_energy", frame_energy, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    function automatic int rv();
        logic [23:0] t;
        t = 24'($urandom);
        case ($urandom_range(0, 3))
            0: return $urandom_range(0, 6) - 3;
            1: return t[0] ? -8388608 : 8388607;
            default: return int'($signed(t));
        endcase
    endfunction

    initial begin
        #2;
        do_reset();
        // single peak, exact latency, then handshake clears
        set_all(0, 0);
        fre[3] = 1000;
        send_frame(0);
        idle(1);
        check("lat1", peak_valid, 0);
        idle(1);
        check("lat2", peak_valid, 0);
        idle(1);
        check("lat3", peak_valid, 1);
        check("t1_idx", peak_idx, 3);
        check("t1_pow", peak_pow, 1000000);
        rmode = 1;
        idle(1);
        check("t1_clr", peak_valid, 0);
        rmode = 0;
        // tie keeps lower index
        set_all(1, 1);
        fre[2] = 300; fim[2] = -400;
        fre[5] = 300; fim[5] = -400;
        send_frame(2);
        idle(4);
        check("tie_idx", peak_idx, 2);
        check("tie_pow", peak_pow, 250000);
        rmode = 1;
        idle(1);
        rmode = 0;
        // extreme magnitude
        set_all(0, 0);
        fre[6] = -8388608; fim[6] = -8388608;
        send_frame(0);
        idle(4);
        check("ext_idx", peak_idx, 6);
        check("ext_pow", peak_pow, 64'd140737488355328);
`ifdef FFT_PEAK_SUM_EN
        check("ext_energy", frame_energy, 64'd140737488355328);
`endif
        // back-to-back frames: no overrun with ready, overrun without
        do_reset();
        rmode = 1;
        set_all(5, 5);
        fre[1] = 7;
        send_frame(0);
        fre[1] = 0; fre[4] = 9;
        send_frame(0);
        idle(4);
        check("ovr_none", overrun, 0);
        rmode = 0;
        fre[1] = 7; fre[4] = 0;
        send_frame(0);
        fre[1] = 0; fre[4] = 9;
        send_frame(0);
        idle(4);
        check("ovr_set", overrun, 1);
        check("ovr_idx", peak_idx, 4);
        // early in_first aborts the partial frame
        do_reset();
        cyc(1, 1, 50, 0);
        for (int i = 1; i < 4; i++) cyc(1, 0, 900, 0);
        set_all(2, 2);
        fre[7] = 40;
        send_frame(0);
        idle(4);
        check("rs_cnt", resync_cnt, 1);
        check("rs_valid", peak_valid, 1);
        check("rs_idx", peak_idx, 7);
        check("rs_single", overrun, 0);
        // stray samples after reset are ignored
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 1234, -77);
        idle(5);
        check("stray_none", peak_valid, 0);
        // reset mid-frame with a result pending
        set_all(0, 3);
        fim[0] = 11;
        send_frame(0);
        idle(4);
        for (int i = 0; i < 3; i++) cyc(1, i == 0, 99, 99);
        do_reset();
        set_all(0, 0);
        fim[5] = -20;
        send_frame(1);
        idle(4);
        check("post_rst_idx", peak_idx, 5);
        check("post_rst_pow", peak_pow, 400);
        // resync counter saturates
        rmode = 2;
        do_reset();
        repeat (260) begin
            cyc(1, 1, 1, 1);
            cyc(1, 0, 2, 2);
        end
        idle(2);
        check("rs_sat", resync_cnt, 255);
        // randomized traffic
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int k;
            k = $urandom_range(0, 99);
            for (int i = 0; i < NPTS; i++) begin
                fre[i] = rv();
                fim[i] = rv();
            end
            if (k < 85) begin
                send_frame(1);
            end else if (k < 93) begin
                for (int i = 0; i < $urandom_range(1, NPTS-1); i++) cyc(1, i == 0, fre[i], fim[i]);
            end else begin
                for (int i = 0; i < $urandom_range(1, 3); i++) cyc(1, 0, fre[i], fim[i]);
            end
            idle($urandom_range(0, 2));
        end
        idle(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
